lfsr_seq_ctrl: RTL and testbench
================================

# lfsr_seq_ctrl

Sequencing controller directly upstream of the LFSR pattern generator. On a start request it writes seed and stop words into the LFSR through the LFSR's config handshake and arms it. It then enables the LFSR one step per accepted word, presenting each word on a valid/ready pixel stream to the downstream grayscale/Sobel path. The run ends at the stop word, at a word-count limit, or on abort.

## Interface
- MAX_PIXEL_BITS, shared parameters header value (≥13), width of the LFSR word and the pixel stream.
- CNT_W, 16, width of the word counter and the limit.

Ports:
- clk_i  in  1  clock.
- nreset_i  in  1  reset; asynchronous and active-low.
- start_i  in  1  start request; sampled only in IDLE.
- abort_i  in  1  abort; any state returns to IDLE.
- seed_i  in  MAX_PIXEL_BITS  seed; captured on start.
- stop_i  in  MAX_PIXEL_BITS  stop word; captured on start.
- limit_i  in  CNT_W  maximum words emitted; 0 means unlimited; captured on start.
- config_o  out  1  to LFSR config_i: 0 = seed, 1 = stop.
- config_rdy_o  out  1  to LFSR config_rdy_i; one-cycle write strobe.
- config_data_o  out  MAX_PIXEL_BITS  to LFSR config_data_i.
- config_done_i  in  1  from LFSR config_done_o; the strobe delayed one cycle.
- lfsr_en_o  out  1  to LFSR lfsr_en_i.
- lfsr_out_i  in  MAX_PIXEL_BITS  from LFSR lfsr_out.
- pixel_o  out  MAX_PIXEL_BITS  stream data; equals lfsr_out_i.
- pixel_valid_o  out  1  stream valid.
- pixel_ready_i  in  1  stream ready.
- busy_o  out  1  high whenever the state is not IDLE.
- done_o  out  1  one-cycle pulse at run end.
- err_o  out  1  sticky error; cleared by the next accepted start.
- count_o  out  CNT_W  words transferred; holds after the run and clears on start.

## Operation
- States: IDLE, CFG_SEED, WAIT_SEED, CFG_STOP, WAIT_STOP, ARM, RUN, DONE.
- IDLE: start_i=1 captures seed_q, stop_q and limit_q, clears count_o and err_o, then goes to CFG_SEED.
- CFG_SEED: one cycle with config_rdy_o=1, config_o=0, config_data_o=seed_q; then WAIT_SEED.
- WAIT_SEED: waits for config_done_i=1, then CFG_STOP.
- CFG_STOP: one cycle with config_rdy_o=1, config_o=1, config_data_o=stop_q; then WAIT_STOP.
- WAIT_STOP: waits for config_done_i=1, then ARM.
- ARM (lfsr_en_o=0, so the LFSR reloads the seed):
  - seed_q==stop_q: go to DONE, count 0, err_o stays 0.
  - lfsr_out_i==seed_q: go to RUN.
  - lfsr_out_i==stop_q (LFSR frozen on a stale match): go to DONE and set err_o.
- RUN:
  - match = (lfsr_out_i==stop_q).
  - lim = (limit_q≠0 && count_o==limit_q).
  - pixel_valid_o = !match && !lim.
  - lfsr_en_o = pixel_valid_o && pixel_ready_i.
  - Each transfer increments count_o, and the LFSR advances on the same edge.
  - match or lim: go to DONE. The stop word is never emitted.
- DONE: done_o=1 for one cycle, then IDLE.
- config_rdy_o, lfsr_en_o and pixel_valid_o are 0 outside the states above.
- abort_i: next state is IDLE. No done_o pulse. count_o holds.
- count_o saturates at all-ones.

## Timing
- Reset values: all outputs 0 and state IDLE.
- start_i at edge 0 gives config_rdy_o high in cycle 1 (seed) and cycle 3 (stop), given config_done_i arrives one cycle after each strobe.
- ARM is cycle 5. The first pixel_valid_o is in cycle 6 at the earliest.
- pixel_o and pixel_valid_o are combinational from state and lfsr_out_i. The next word appears the cycle after a transfer.
- Backpressure: with pixel_ready_i=0, pixel_o holds and lfsr_en_o=0.
- Simultaneous abort_i and start_i in IDLE: abort wins and the run does not start.

## Configuration
- LFSR_SEQ_CTRL_TIMEOUT_EN defined: each of WAIT_SEED, WAIT_STOP and ARM has a 4-cycle watchdog. Expiry sets err_o and goes to DONE.
- Not defined: these states wait indefinitely.

## Test plan
- Basic run: seed=0x0001, stop=0x000F, limit=0 → stream 0x0001, 0x0003, 0x0007; done_o one cycle later; count_o=3; err_o=0.
- Limit: seed=0x0001, stop=0x000F, limit=2 → stream 0x0001, 0x0003; done_o pulses; count_o=2.
- seed=stop=0x0005 → no pixel_valid_o, done_o in cycle 6, count_o=0.
- Backpressure: pixel_ready_i low for 3 cycles after the first transfer → pixel_o stays 0x0003, lfsr_en_o=0, then the stream resumes with 0x0007.
- Abort: abort_i in RUN after 1 transfer → IDLE next cycle, busy_o=0, no done_o, count_o=1.
- Config handshake stall, LFSR_SEQ_CTRL_TIMEOUT_EN defined, config_done_i tied 0 → err_o=1 and done_o pulses 4 cycles after entering WAIT_SEED. Without the macro, busy_o stays 1 and nothing else happens.

Source files
------------

// File: rtl/lfsr_seq_ctrl_if.sv
// Bundle between lfsr_seq_ctrl and the LFSR pattern generator plus the pixel stream it feeds.
// The master side is the sequencing controller; the slave side is the LFSR/stream consumer.
interface lfsr_seq_ctrl_if #(
  parameter int MAX_PIXEL_BITS = 16
);
  logic                      config_o;
  logic                      config_rdy_o;
  logic [MAX_PIXEL_BITS-1:0] config_data_o;
  logic                      config_done_i;
  logic                      lfsr_en_o;
  logic [MAX_PIXEL_BITS-1:0] lfsr_out_i;
  logic [MAX_PIXEL_BITS-1:0] pixel_o;
  logic                      pixel_valid_o;
  logic                      pixel_ready_i;

  modport master (
    output config_o, config_rdy_o, config_data_o, lfsr_en_o, pixel_o, pixel_valid_o,
    input  config_done_i, lfsr_out_i, pixel_ready_i
  );

  modport slave (
    input  config_o, config_rdy_o, config_data_o, lfsr_en_o, pixel_o, pixel_valid_o,
    output config_done_i, lfsr_out_i, pixel_ready_i
  );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Sequencing controller: configures seed/stop into the LFSR, then streams one word per transfer.
// Optional macro LFSR_SEQ_CTRL_TIMEOUT_EN adds a 4-cycle watchdog on WAIT_SEED, WAIT_STOP and ARM.
module lfsr_seq_ctrl #(
  parameter int MAX_PIXEL_BITS = 16,
  parameter int CNT_W          = 16
) (
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [MAX_PIXEL_BITS-1:0] seed_i,
  input  logic [MAX_PIXEL_BITS-1:0] stop_i,
  input  logic [CNT_W-1:0]          limit_i,
  lfsr_seq_ctrl_if.master           bus,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [CNT_W-1:0]          count_o
);

  typedef enum logic [2:0] {
    IDLE, CFG_SEED, WAIT_SEED, CFG_STOP, WAIT_STOP, ARM, RUN, DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [MAX_PIXEL_BITS-1:0] seed_q, stop_q;
  logic [CNT_W-1:0]          limit_q;
  logic [CNT_W-1:0]          count_q;
  logic                      err_q;

  logic                      start_acc;
  logic                      xfer;
  logic                      set_err;
  logic                      match;
  logic                      lim;
  logic                      wd_exp;

  logic                      cfg_sel;
  logic                      cfg_rdy;
  logic [MAX_PIXEL_BITS-1:0] cfg_data;
  logic                      en;
  logic                      valid;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef LFSR_SEQ_CTRL_TIMEOUT_EN
  // Watchdog restarts on every state change; expiry is the 4th cycle spent in one state.
  logic [1:0] wd_q;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wd_q <= '0;
    end else if (state_d != state_q) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 2'd1;
    end
  end

  assign wd_exp = (wd_q == 2'd3);
`else
  assign wd_exp = 1'b0;
`endif

  // Run parameters are captured on an accepted start and need no reset.
  always_ff @(posedge clk_i) begin
    if (start_acc) begin
      seed_q  <= seed_i;
      stop_q  <= stop_i;
      limit_q <= limit_i;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        count_q <= '0;
      end else if (xfer) begin
        count_q <= sat_inc(count_q);
      end
      if (start_acc) begin
        err_q <= 1'b0;
      end else if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign match = (bus.lfsr_out_i == stop_q);
  assign lim   = (limit_q != '0) && (count_q == limit_q);

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    xfer      = 1'b0;
    set_err   = 1'b0;
    cfg_sel   = 1'b0;
    cfg_rdy   = 1'b0;
    cfg_data  = '0;
    en        = 1'b0;
    valid     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          start_acc = 1'b1;
          state_d   = CFG_SEED;
        end
      end
      CFG_SEED: begin
        cfg_rdy  = 1'b1;
        cfg_sel  = 1'b0;
        cfg_data = seed_q;
        state_d  = WAIT_SEED;
      end
      WAIT_SEED: begin
        if (bus.config_done_i) begin
          state_d = CFG_STOP;
        end else if (wd_exp) begin
          set_err = 1'b1;
          state_d = DONE;
        end
      end
      CFG_STOP: begin
        cfg_rdy  = 1'b1;
        cfg_sel  = 1'b1;
        cfg_data = stop_q;
        state_d  = WAIT_STOP;
      end
      WAIT_STOP: begin
        if (bus.config_done_i) begin
          state_d = ARM;
        end else if (wd_exp) begin
          set_err = 1'b1;
          state_d = DONE;
        end
      end
      ARM: begin
        // A degenerate seed==stop run is legal and ends cleanly with nothing emitted.
        if (seed_q == stop_q) begin
          state_d = DONE;
        end else if (bus.lfsr_out_i == seed_q) begin
          state_d = RUN;
        end else if (match) begin
          set_err = 1'b1;
          state_d = DONE;
        end else if (wd_exp) begin
          set_err = 1'b1;
          state_d = DONE;
        end
      end
      RUN: begin
        valid = !match && !lim;
        en    = valid && bus.pixel_ready_i;
        xfer  = en;
        if (match || lim) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_i) begin
      state_d = IDLE;
    end
  end

  assign bus.config_o      = cfg_sel;
  assign bus.config_rdy_o  = cfg_rdy;
  assign bus.config_data_o = cfg_data;
  assign bus.lfsr_en_o     = en;
  assign bus.pixel_o       = bus.lfsr_out_i;
  assign bus.pixel_valid_o = valid;

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign err_o   = err_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a behavioural 16-bit XNOR LFSR (taps 16,14,13,11).
module tb_lfsr_seq_ctrl;
  localparam int W  = 16;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          nreset_i;
  logic          start_i, abort_i;
  logic [W-1:0]  seed_i, stop_i;
  logic [CW-1:0] limit_i;
  logic          busy_o, done_o, err_o;
  logic [CW-1:0] count_o;

  logic          stall_cfg;
  logic          done_q;
  logic [W-1:0]  lfsr_q;

  int checks = 0;
  int errors = 0;

  lfsr_seq_ctrl_if #(.MAX_PIXEL_BITS(W)) bus ();

  lfsr_seq_ctrl #(.MAX_PIXEL_BITS(W), .CNT_W(CW)) dut (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .start_i  (start_i),
    .abort_i  (abort_i),
    .seed_i   (seed_i),
    .stop_i   (stop_i),
    .limit_i  (limit_i),
    .bus      (bus.master),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .count_o  (count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] x);
    return {x[W-2:0], ~(x[15] ^ x[13] ^ x[12] ^ x[10])};
  endfunction

  // LFSR model: seed write loads the register, enable advances it, done echoes the strobe.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      lfsr_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= bus.config_rdy_o;
      if (bus.config_rdy_o && !bus.config_o) lfsr_q <= bus.config_data_o;
      else if (bus.lfsr_en_o)                lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign bus.lfsr_out_i    = lfsr_q;
  assign bus.config_done_i = done_q && !stall_cfg;

  task automatic next_cycle();
    @(negedge clk_i);
    #1;
  endtask

  // Leaves the bench at cycle 1 (edge 0 sampled start_i).
  task automatic start_run(input logic [W-1:0] s, input logic [W-1:0] p, input logic [CW-1:0] l);
    @(negedge clk_i);
    start_i = 1'b1; seed_i = s; stop_i = p; limit_i = l;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    nreset_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if ({busy_o, done_o, err_o, bus.config_rdy_o, bus.lfsr_en_o, bus.pixel_valid_o, bus.config_o} !== 7'b0 ||
        count_o !== '0 || bus.config_data_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b rdy=%b en=%b vld=%b cnt=%h cdata=%h, required all 0",
               busy_o, done_o, err_o, bus.config_rdy_o, bus.lfsr_en_o, bus.pixel_valid_o, count_o, bus.config_data_o);
    end
    @(negedge clk_i);
    nreset_i = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_px [3];
    exp_px[0] = 16'h0001; exp_px[1] = 16'h0003; exp_px[2] = 16'h0007;
    start_run(16'h0001, 16'h000F, 16'd0);
    checks++;
    if (!(bus.config_rdy_o === 1'b1 && bus.config_o === 1'b0 && bus.config_data_o === 16'h0001 && busy_o === 1'b1)) begin
      errors++;
      $display("FAIL basic_cfg_seed: rdy=%b cfg=%b data=%h busy=%b, required 1 0 0001 1",
               bus.config_rdy_o, bus.config_o, bus.config_data_o, busy_o);
    end
    next_cycle();
    checks++;
    if (bus.config_rdy_o !== 1'b0) begin
      errors++; $display("FAIL basic_wait_seed_rdy: got %b required 0", bus.config_rdy_o);
    end
    next_cycle();
    checks++;
    if (!(bus.config_rdy_o === 1'b1 && bus.config_o === 1'b1 && bus.config_data_o === 16'h000F)) begin
      errors++;
      $display("FAIL basic_cfg_stop: rdy=%b cfg=%b data=%h, required 1 1 000f",
               bus.config_rdy_o, bus.config_o, bus.config_data_o);
    end
    next_cycle();
    next_cycle();
    checks++;
    if (bus.pixel_valid_o !== 1'b0 || bus.lfsr_en_o !== 1'b0) begin
      errors++; $display("FAIL basic_arm: vld=%b en=%b required 0 0", bus.pixel_valid_o, bus.lfsr_en_o);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checks++;
      if (bus.pixel_valid_o !== 1'b1 || bus.pixel_o !== exp_px[i] || bus.lfsr_en_o !== 1'b1) begin
        errors++;
        $display("FAIL basic_pixel%0d: vld=%b px=%h en=%b required 1 %h 1",
                 i, bus.pixel_valid_o, bus.pixel_o, bus.lfsr_en_o, exp_px[i]);
      end
    end
    next_cycle();
    checks++;
    if (bus.pixel_valid_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL basic_stop_word: vld=%b done=%b required 0 0", bus.pixel_valid_o, done_o);
    end
    next_cycle();
    checks++;
    if (done_o !== 1'b1 || count_o !== 16'd3 || err_o !== 1'b0) begin
      errors++; $display("FAIL basic_done: done=%b cnt=%0d err=%b required 1 3 0", done_o, count_o, err_o);
    end
    next_cycle();
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || count_o !== 16'd3) begin
      errors++; $display("FAIL basic_idle: done=%b busy=%b cnt=%0d required 0 0 3", done_o, busy_o, count_o);
    end
  endtask

  task automatic test_limit();
    logic [W-1:0] exp_px [2];
    exp_px[0] = 16'h0001; exp_px[1] = 16'h0003;
    start_run(16'h0001, 16'h000F, 16'd2);
    checks++;
    if (count_o !== 16'd0) begin
      errors++; $display("FAIL limit_count_clear: got %0d required 0", count_o);
    end
    repeat (4) next_cycle();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      checks++;
      if (bus.pixel_valid_o !== 1'b1 || bus.pixel_o !== exp_px[i]) begin
        errors++; $display("FAIL limit_pixel%0d: vld=%b px=%h required 1 %h", i, bus.pixel_valid_o, bus.pixel_o, exp_px[i]);
      end
    end
    next_cycle();
    checks++;
    if (bus.pixel_valid_o !== 1'b0 || bus.lfsr_en_o !== 1'b0) begin
      errors++; $display("FAIL limit_reached: vld=%b en=%b required 0 0", bus.pixel_valid_o, bus.lfsr_en_o);
    end
    next_cycle();
    checks++;
    if (done_o !== 1'b1 || count_o !== 16'd2 || err_o !== 1'b0) begin
      errors++; $display("FAIL limit_done: done=%b cnt=%0d err=%b required 1 2 0", done_o, count_o, err_o);
    end
    next_cycle();
  endtask

  task automatic test_seed_eq_stop();
    int seen_valid = 0;
    start_run(16'h0005, 16'h0005, 16'd0);
    for (int c = 1; c <= 5; c++) begin
      if (bus.pixel_valid_o !== 1'b0) seen_valid++;
      if (c < 5) next_cycle();
    end
    next_cycle();
    if (bus.pixel_valid_o !== 1'b0) seen_valid++;
    checks++;
    if (seen_valid != 0) begin
      errors++; $display("FAIL eq_no_valid: valid cycles=%0d required 0", seen_valid);
    end
    checks++;
    if (done_o !== 1'b1 || count_o !== 16'd0 || err_o !== 1'b0) begin
      errors++; $display("FAIL eq_done_c6: done=%b cnt=%0d err=%b required 1 0 0", done_o, count_o, err_o);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    start_run(16'h0001, 16'h000F, 16'd0);
    repeat (5) next_cycle();
    checks++;
    if (bus.pixel_o !== 16'h0001 || bus.lfsr_en_o !== 1'b1) begin
      errors++; $display("FAIL bp_first: px=%h en=%b required 0001 1", bus.pixel_o, bus.lfsr_en_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      bus.pixel_ready_i = 1'b0;
      #1;
      checks++;
      if (bus.pixel_o !== 16'h0003 || bus.lfsr_en_o !== 1'b0 || bus.pixel_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: px=%h en=%b vld=%b required 0003 0 1", i, bus.pixel_o, bus.lfsr_en_o, bus.pixel_valid_o);
      end
    end
    @(negedge clk_i);
    bus.pixel_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.pixel_o !== 16'h0003 || bus.lfsr_en_o !== 1'b1) begin
      errors++; $display("FAIL bp_release: px=%h en=%b required 0003 1", bus.pixel_o, bus.lfsr_en_o);
    end
    next_cycle();
    checks++;
    if (bus.pixel_o !== 16'h0007 || bus.pixel_valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_resume: px=%h vld=%b required 0007 1", bus.pixel_o, bus.pixel_valid_o);
    end
    next_cycle();
    next_cycle();
    checks++;
    if (done_o !== 1'b1 || count_o !== 16'd3) begin
      errors++; $display("FAIL bp_done: done=%b cnt=%0d required 1 3", done_o, count_o);
    end
    next_cycle();
  endtask

  task automatic test_abort();
    start_run(16'h0001, 16'h000F, 16'd0);
    repeat (5) next_cycle();
    @(negedge clk_i);
    bus.pixel_ready_i = 1'b0;
    abort_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b1 || bus.lfsr_en_o !== 1'b0 || count_o !== 16'd1) begin
      errors++; $display("FAIL abort_in_run: busy=%b en=%b cnt=%0d required 1 0 1", busy_o, bus.lfsr_en_o, count_o);
    end
    @(negedge clk_i);
    abort_i = 1'b0;
    bus.pixel_ready_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || count_o !== 16'd1) begin
      errors++; $display("FAIL abort_idle: busy=%b done=%b cnt=%0d required 0 0 1", busy_o, done_o, count_o);
    end
    next_cycle();
    checks++;
    if (done_o !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: got %b required 0", done_o);
    end
  endtask

  task automatic test_abort_start();
    @(negedge clk_i);
    start_i = 1'b1; abort_i = 1'b1;
    seed_i = 16'h0001; stop_i = 16'h000F; limit_i = 16'd0;
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || bus.config_rdy_o !== 1'b0 || count_o !== 16'd1) begin
      errors++; $display("FAIL abort_beats_start: busy=%b rdy=%b cnt=%0d required 0 0 1", busy_o, bus.config_rdy_o, count_o);
    end
  endtask

  task automatic test_cfg_stall();
    int bad = 0;
    stall_cfg = 1'b1;
    start_run(16'h0001, 16'h000F, 16'd0);
    for (int c = 2; c <= 5; c++) begin
      next_cycle();
      if (busy_o !== 1'b1 || done_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_wait: bad cycles=%0d required 0", bad);
    end
    next_cycle();
`ifdef LFSR_SEQ_CTRL_TIMEOUT_EN
    checks++;
    if (done_o !== 1'b1 || err_o !== 1'b1) begin
      errors++; $display("FAIL stall_timeout: done=%b err=%b required 1 1", done_o, err_o);
    end
    next_cycle();
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b1) begin
      errors++; $display("FAIL stall_sticky: busy=%b err=%b required 0 1", busy_o, err_o);
    end
    stall_cfg = 1'b0;
    start_run(16'h0001, 16'h000F, 16'd0);
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL stall_err_clear: got %b required 0", err_o);
    end
`else
    bad = 0;
    for (int c = 6; c <= 12; c++) begin
      if (busy_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0) bad++;
      next_cycle();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_forever: bad cycles=%0d required 0", bad);
    end
    stall_cfg = 1'b0;
`endif
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL stall_abort: busy=%b done=%b required 0 0", busy_o, done_o);
    end
  endtask

  initial begin
    start_i = 1'b0; abort_i = 1'b0;
    seed_i = '0; stop_i = '0; limit_i = '0;
    stall_cfg = 1'b0;
    bus.pixel_ready_i = 1'b1;
    test_reset();
    test_basic();
    test_limit();
    test_seed_eq_stop();
    test_backpressure();
    test_abort();
    test_abort_start();
    test_cfg_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, required completion");
    $fatal(1);
  end
endmodule
